// File: rtl/nco_sweep_ctrl_if.sv
// Control/status bundle between a sweep sequencer and nco_sweep_ctrl.
// Carries sweep parameters, NCO handshake and sweep status.
interface nco_sweep_ctrl_if #(
    parameter int APR = 32,
    parameter int DW  = 16
);
    logic           start;
    logic           abort;
    logic [APR-1:0] f_start;
    logic [APR-1:0] f_stop;
    logic [APR-1:0] f_step;
    logic [DW-1:0]  dwell;
    logic           nco_out_valid;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken_o;
    logic           busy;
    logic           sweep_valid;
    logic           done;

    modport master (
        output start, abort, f_start, f_stop, f_step, dwell, nco_out_valid,
        input  phi_inc_o, nco_clken_o, busy, sweep_valid, done
    );

    modport slave (
        input  start, abort, f_start, f_stop, f_step, dwell, nco_out_valid,
        output phi_inc_o, nco_clken_o, busy, sweep_valid, done
    );
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep controller driving an NCO phase increment.
// Define NCO_SWEEP_BIDIR_EN to allow downward sweeps when f_start > f_stop.
module nco_sweep_ctrl #(
    parameter int APR = 32,
    parameter int DW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    nco_sweep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_DWELL,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_nxt_state;
    logic [APR-1:0] r_phi;
    logic [APR-1:0] w_nxt_phi;
    logic [APR-1:0] r_f_stop;
    logic [APR-1:0] w_nxt_f_stop;
    logic [APR-1:0] r_f_step;
    logic [APR-1:0] w_nxt_f_step;
    logic [DW-1:0]  r_dwell_m1;
    logic [DW-1:0]  w_nxt_dwell_m1;
    logic [DW-1:0]  r_cnt;
    logic [DW-1:0]  w_nxt_cnt;
    logic           r_single;
    logic           w_nxt_single;
    logic           r_clken;
    logic           w_nxt_clken;
    logic           r_busy;
    logic           w_nxt_busy;
    logic           r_done;
    logic           w_nxt_done;

    logic [APR:0]   w_sum;
    logic [APR-1:0] w_step_up;
    logic [APR-1:0] w_step_val;
    logic           w_start_single;

    // Carry out of the APR+1 bit sum means we overshot f_stop.
    assign w_sum     = {1'b0, r_phi} + {1'b0, r_f_step};
    assign w_step_up = (w_sum > {1'b0, r_f_stop}) ? r_f_stop : w_sum[APR-1:0];

`ifdef NCO_SWEEP_BIDIR_EN
    logic           r_down;
    logic           w_nxt_down;
    logic [APR:0]   w_diff;
    logic [APR-1:0] w_step_dn;

    // Borrow or undershoot both clamp to f_stop.
    assign w_diff     = {1'b0, r_phi} - {1'b0, r_f_step};
    assign w_step_dn  = (w_diff[APR] || (w_diff[APR-1:0] < r_f_stop)) ?
                        r_f_stop : w_diff[APR-1:0];
    assign w_step_val = r_down ? w_step_dn : w_step_up;
    assign w_start_single = (bus.f_step == '0);
    assign w_nxt_down = (r_state == S_IDLE) ? (bus.f_start > bus.f_stop) : r_down;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_down <= 1'b0;
        end else begin
            r_down <= w_nxt_down;
        end
    end
`else
    assign w_step_val = w_step_up;
    assign w_start_single = (bus.f_step == '0) || (bus.f_start > bus.f_stop);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_phi      <= '0;
            r_f_stop   <= '0;
            r_f_step   <= '0;
            r_dwell_m1 <= '0;
            r_cnt      <= '0;
            r_single   <= 1'b0;
            r_clken    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_phi      <= w_nxt_phi;
            r_f_stop   <= w_nxt_f_stop;
            r_f_step   <= w_nxt_f_step;
            r_dwell_m1 <= w_nxt_dwell_m1;
            r_cnt      <= w_nxt_cnt;
            r_single   <= w_nxt_single;
            r_clken    <= w_nxt_clken;
            r_busy     <= w_nxt_busy;
            r_done     <= w_nxt_done;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_phi      = r_phi;
        w_nxt_f_stop   = r_f_stop;
        w_nxt_f_step   = r_f_step;
        w_nxt_dwell_m1 = r_dwell_m1;
        w_nxt_cnt      = r_cnt;
        w_nxt_single   = r_single;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_nxt_phi      = bus.f_start;
                    w_nxt_f_stop   = bus.f_stop;
                    w_nxt_f_step   = bus.f_step;
                    w_nxt_dwell_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DW'(1);
                    w_nxt_single   = w_start_single;
                    w_nxt_state    = S_PRIME;
                end
            end
            S_PRIME: begin
                if (bus.nco_out_valid) begin
                    w_nxt_cnt   = r_dwell_m1;
                    w_nxt_state = S_DWELL;
                end
            end
            S_DWELL: begin
                if (bus.nco_out_valid) begin
                    if (r_cnt != '0) begin
                        w_nxt_cnt = r_cnt - DW'(1);
                    end else if (r_single || (r_phi == r_f_stop)) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_phi = w_step_val;
                        w_nxt_cnt = r_dwell_m1;
                    end
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        if (r_state != S_IDLE && bus.abort) begin
            w_nxt_state = S_IDLE;
        end

        w_nxt_busy  = (w_nxt_state != S_IDLE);
        w_nxt_clken = (w_nxt_state == S_PRIME) || (w_nxt_state == S_DWELL);
        w_nxt_done  = (w_nxt_state == S_DONE);
    end

    assign bus.phi_inc_o   = r_phi;
    assign bus.nco_clken_o = r_clken;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.sweep_valid = bus.nco_out_valid & (r_state == S_DWELL);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomized self-checking bench for nco_sweep_ctrl.
// Expected sample sequences come from a frequency-list model of the sweep.
module tb_nco_sweep_ctrl;

    localparam int APR = 32;
    localparam int DW  = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    nco_sweep_ctrl_if #(.APR(APR), .DW(DW)) bus();

    nco_sweep_ctrl #(.APR(APR), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Each frequency of the sweep repeated max(dwell,1) times.
    task automatic model(input longint fs, input longint fe,
                         input longint st, input int dw);
        longint f;
        int n;
        exp_q.delete();
        f = fs;
        n = (dw == 0) ? 1 : dw;
        while (1) begin
            for (int i = 0; i < n; i++) exp_q.push_back(f[31:0]);
            if (f == fe || st == 0) break;
            if (fs > fe) begin
`ifdef NCO_SWEEP_BIDIR_EN
                f = (f - st < fe) ? fe : f - st;
`else
                break;
`endif
            end else begin
                f = (f + st > fe) ? fe : f + st;
            end
        end
    endtask

    task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] st, input logic [15:0] dw,
                             input int mode, input string name);
        logic [31:0] obs[$];
        int budget;
        bit seen_done;
        bit bad;
        seen_done = 0;
        model(fs, fe, st, dw);
        budget = exp_q.size() * 4 + 60;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.f_start = fs;
        bus.f_stop = fe;
        bus.f_step = st;
        bus.dwell = dw;
        bus.nco_out_valid = 1'($urandom % 2);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.nco_clken_o !== 1'b1 || bus.phi_inc_o !== fs) begin
            errors++;
            $display("FAIL %s.prime: busy=%b clken=%b phi=%h, required 1 1 %h",
                     name, bus.busy, bus.nco_clken_o, bus.phi_inc_o, fs);
        end
        for (int cyc = 0; cyc < budget && !seen_done; cyc++) begin
            case (mode)
                0:       bus.nco_out_valid = 1'b1;
                1:       bus.nco_out_valid = (cyc % 3 == 0);
                default: bus.nco_out_valid = 1'($urandom % 2);
            endcase
            bus.start = 1'($urandom % 2);
            bus.f_start = $urandom;
            bus.f_stop = $urandom;
            bus.f_step = $urandom;
            bus.dwell = 16'($urandom);
            #1;
            if (bus.sweep_valid === 1'b1) obs.push_back(bus.phi_inc_o);
            checks++;
            if (bus.nco_out_valid === 1'b0 && bus.sweep_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s.qual: sweep_valid=%b with nco_out_valid=0, required 0",
                         name, bus.sweep_valid);
            end
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1;
        end
        bus.start = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s.timeout: no done within %0d cycles", name, budget);
        end else begin
            checks++;
            if (bus.nco_clken_o !== 1'b0 || bus.busy !== 1'b1 ||
                bus.phi_inc_o !== exp_q[exp_q.size()-1]) begin
                errors++;
                $display("FAIL %s.done_state: clken=%b busy=%b phi=%h, required 0 1 %h",
                         name, bus.nco_clken_o, bus.busy, bus.phi_inc_o,
                         exp_q[exp_q.size()-1]);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s.idle_after: done=%b busy=%b, required 0 0",
                         name, bus.done, bus.busy);
            end
        end
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s.count: %0d samples, required %0d",
                     name, obs.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < obs.size() && i < exp_q.size() && !bad; i++) begin
            if (obs[i] !== exp_q[i]) begin
                bad = 1;
                $display("FAIL %s.freq[%0d]: phi=%h, required %h",
                         name, i, obs[i], exp_q[i]);
            end
        end
        checks++;
        if (bad) errors++;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.f_start = '0;
        bus.f_stop = '0;
        bus.f_step = '0;
        bus.dwell = '0;
        bus.nco_out_valid = 1'b1;
        reset_n = 1'b0;
        #12;
        checks++;
        if (bus.phi_inc_o !== '0 || bus.nco_clken_o !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.sweep_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: phi=%h clken=%b busy=%b done=%b sv=%b, required all 0",
                     bus.phi_inc_o, bus.nco_clken_o, bus.busy, bus.done, bus.sweep_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.sweep_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b sv=%b, required 0 0",
                     bus.busy, bus.sweep_valid);
        end
    endtask

    task automatic test_directed();
        run_sweep(32'd100, 32'd130, 32'd10, 16'd4, 0, "basic");
        run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd3, 0, "clamp");
        run_sweep(32'd100, 32'd130, 32'd10, 16'd2, 1, "gapped");
        run_sweep(32'd200, 32'd170, 32'd10, 16'd2, 0, "reverse");
        run_sweep(32'd50, 32'd90, 32'd0, 16'd0, 2, "zero_step");
        run_sweep(32'd77, 32'd77, 32'd5, 16'd1, 0, "equal");
    endtask

    task automatic test_abort();
        int n;
        int cyc;
        bit saw_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.f_start = 32'd1000;
        bus.f_stop = 32'd1100;
        bus.f_step = 32'd10;
        bus.dwell = 16'd3;
        bus.nco_out_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            #1;
            if (bus.sweep_valid === 1'b1) n++;
            cyc++;
        end
        checks++;
        if (n != 4 || bus.phi_inc_o !== 32'd1010) begin
            errors++;
            $display("FAIL abort.second_dwell: samples=%0d phi=%0d, required 4 1010",
                     n, bus.phi_inc_o);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.nco_clken_o !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort.idle: busy=%b clken=%b done=%b, required 0 0 0",
                     bus.busy, bus.nco_clken_o, bus.done);
        end
        bus.abort = 1'b0;
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort.quiet: done/busy rose after abort, required 0");
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort.start_ignored: busy=%b, required 0", bus.busy);
        end
        run_sweep(32'd1000, 32'd1030, 32'd10, 16'd2, 0, "restart");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1;
        bus.f_start = 32'd500;
        bus.f_stop = 32'd900;
        bus.f_step = 32'd50;
        bus.dwell = 16'd5;
        bus.nco_out_valid = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.phi_inc_o !== '0 || bus.nco_clken_o !== 1'b0 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.sweep_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: phi=%h clken=%b busy=%b done=%b sv=%b, required all 0",
                     bus.phi_inc_o, bus.nco_clken_o, bus.busy, bus.done, bus.sweep_valid);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.phi_inc_o !== '0) begin
            errors++;
            $display("FAIL reset_mid.release: busy=%b phi=%h, required 0 0",
                     bus.busy, bus.phi_inc_o);
        end
        run_sweep(32'd500, 32'd600, 32'd50, 16'd2, 2, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] fs;
        logic [31:0] st;
        logic [31:0] fe;
        longint span;
        longint fe64;
        int n;
        for (int k = 0; k < 10; k++) begin
            fs = $urandom;
            n = $urandom_range(1, 5);
            st = $urandom_range(1, 1000);
            span = longint'(st) * n - $urandom_range(0, st - 1);
            if ($urandom % 4 == 0) begin
                fe64 = longint'(fs) - span;
                if (fe64 < 0) fe64 = 0;
            end else begin
                fe64 = longint'(fs) + span;
                if (fe64 > 64'hFFFF_FFFF) fe64 = 64'hFFFF_FFFF;
            end
            fe = fe64[31:0];
            run_sweep(fs, fe, st, 16'($urandom_range(0, 4)),
                      $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter APR, default 32, phase-increment width matching the NCO phi_inc_i port.
REQ-002 SHALL have parameter DW, default 16, dwell counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  sweep request pulse; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate sweep.
REQ-007 SHALL have port f_start  input  APR  first phase increment, unsigned.
REQ-008 SHALL have port f_stop  input  APR  final phase increment, unsigned.
REQ-009 SHALL have port f_step  input  APR  increment change per step, unsigned.
REQ-010 SHALL have port dwell  input  DW  valid NCO samples per frequency; 0 treated as 1.
REQ-011 SHALL have port nco_out_valid  input  1  NCO out_valid.
REQ-012 SHALL have port phi_inc_o  output  APR  drives NCO phi_inc_i.
REQ-013 SHALL have port nco_clken_o  output  1  drives NCO clken.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port sweep_valid  output  1  nco_out_valid qualified by state DWELL.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, PRIME, DWELL, DONE, all outputs registered except sweep_valid (combinational AND).
REQ-018 IDLE: on start=1 and abort=0, SHALL latch f_start/f_stop/f_step/dwell, load phi_inc_o=f_start, set nco_clken_o=1, enter PRIME next cycle; inputs thereafter ignored until IDLE.
REQ-019 PRIME: SHALL wait, with no timeout, for nco_out_valid=1, then enter DWELL with dwell counter loaded to max(dwell,1)-1.
REQ-020 DWELL: counter SHALL decrement only on cycles with nco_out_valid=1; sample at count 0 is last sample of current frequency.
REQ-021 At last sample: if phi_inc_o == f_stop, or step invalid per REQ-023, SHALL enter DONE; else phi_inc_o SHALL update next cycle to min(phi_inc_o+f_step, f_stop), computed in APR+1 bits so carry-out clamps to f_stop, and counter reloads.
REQ-022 phi_inc_o changes SHALL occur only in the cycle after a last sample; new frequency dwell counting starts immediately (NCO pipeline latency is not masked).
REQ-023 f_step=0, or f_start>f_stop (macro undefined), SHALL yield exactly one dwell at f_start then DONE.
REQ-024 DONE: done=1 for exactly one cycle, nco_clken_o=0, phi_inc_o holds last value, next state IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE next cycle, nco_clken_o=0, no done pulse; abort with start in IDLE: abort wins, start ignored.
REQ-026 start while busy=1 SHALL be ignored.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, phi_inc_o=0, nco_clken_o=0, busy=0, done=0, counter=0; sweep_valid=0 follows.
REQ-028 Reset mid-sweep SHALL discard latched parameters; first valid operation after release is a new start.

Configuration
REQ-029 Macro NCO_SWEEP_BIDIR_EN defined: f_start>f_stop SHALL sweep downward, phi_inc_o=max(phi_inc_o-f_step, f_stop) with borrow clamping to f_stop; f_start==f_stop single dwell.
REQ-030 Macro NCO_SWEEP_BIDIR_EN undefined: no subtract path compiled; REQ-023 applies.

Verification
REQ-031 f_start=100, f_stop=130, f_step=10, dwell=4, valid always 1 after PRIME -> phi_inc_o 100,110,120,130, 4 sweep_valid each, 16 total, then done pulse.
REQ-032 f_start=0xFFFFFFF0, f_stop=0xFFFFFFFF, f_step=0x20 -> second frequency clamps to 0xFFFFFFFF, then DONE.
REQ-033 Gapped nco_out_valid (1 of every 3 cycles), dwell=2 -> exactly 2 sweep_valid per frequency; counter frozen on gaps.
REQ-034 abort asserted during 2nd dwell -> IDLE next cycle, nco_clken_o=0, done never asserted; new start then restarts at f_start.
REQ-035 reset_n pulsed low mid-DWELL -> all outputs 0 immediately, IDLE after release.
REQ-036 f_start=200, f_stop=170, f_step=10: with NCO_SWEEP_BIDIR_EN -> 200,190,180,170 then done; without -> single dwell at 200 then done.
